// File: rtl/mux_cfg_bank_pkg.sv
// Register map and decode helpers for the mux select control bank.
package mux_cfg_pkg;

  localparam int DEC_W = 8;
  localparam int CNT_W = 16;

  localparam logic [DEC_W-1:0] SHADOW_BASE   = 8'h00;
  localparam logic [DEC_W-1:0] CTRL_OFF      = 8'h40;
  localparam logic [DEC_W-1:0] STATUS_OFF    = 8'h44;
  localparam logic [DEC_W-1:0] APPLY_CNT_OFF = 8'h48;

  localparam int CTRL_APPLY  = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_TRG_EN = 2;

  typedef struct packed {
    logic       sh;
    logic [3:0] idx;
    logic       ctrl;
    logic       stat;
    logic       cnt;
  } dec_t;

  function automatic dec_t decode(input logic [DEC_W-1:0] a, input int nch);
    dec_t             d;
    logic [DEC_W-1:0] off;
    off    = a - SHADOW_BASE;
    d.sh   = (off[1:0] == 2'b00) && (32'(off[DEC_W-1:2]) < nch);
    d.idx  = off[5:2];
    d.ctrl = (a == CTRL_OFF);
    d.stat = (a == STATUS_OFF);
    d.cnt  = (a == APPLY_CNT_OFF);
    return d;
  endfunction

endpackage

// File: rtl/mux_cfg_bank_if.sv
// Simple register bus: one-cycle ack, registered rdata/err.
interface sys_bus_if;
  logic        clk;
  logic        rstn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (input clk, rstn, rdata, ack, err, output addr, wdata, wen, ren);
  modport slave  (input clk, rstn, addr, wdata, wen, ren, output rdata, ack, err);
endinterface

// File: rtl/mux_cfg_bank_field.sv
// One select channel: shadow/active pair, legality check and change detect.
module mux_cfg_field #(
  parameter int SW   = 2,
  parameter int NSEL = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_i,
  input  logic [31:0]   wdata_i,
  input  logic          auto_i,
  input  logic          apply_i,
  output logic          wr_ok_o,
  output logic [SW-1:0] shadow_o,
  output logic [SW-1:0] act_o,
  output logic          chg_o,
  output logic          pend_o
);

  logic [SW-1:0] shadow_q, shadow_d, act_q, act_d, src;
  logic          legal;

  // Whole-word compare also rejects any stray bits above SW.
  assign legal   = (wdata_i < 32'(NSEL));
  assign wr_ok_o = wr_i & legal;

  always_comb begin
    src      = (wr_ok_o & auto_i) ? wdata_i[SW-1:0] : shadow_q;
    act_d    = apply_i ? src : act_q;
    shadow_d = wr_ok_o ? wdata_i[SW-1:0] : shadow_q;
  end

  assign chg_o  = (act_d != act_q);
  assign pend_o = wr_ok_o & ~auto_i & (wdata_i[SW-1:0] != act_d);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      act_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      act_q    <= act_d;
    end
  end

  assign shadow_o = shadow_q;
  assign act_o    = act_q;

endmodule

// File: rtl/mux_cfg_bank.sv
// Mux select control bank: shadowed select fields applied atomically by
// software strobe, external trigger, or immediately in auto mode.
module mux_cfg_bank
  import mux_cfg_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SW   = 2,
  parameter int NSEL = 4
) (
  sys_bus_if.slave                bus,
  input  logic                    trg_i,
  output logic [NCH-1:0][SW-1:0]  mux_o,
  output logic                    mux_upd_o
);

  dec_t                   dec;
  logic                   acc, ctrl_wr, apply, wr_ok_any, mapped, err_d;
  logic [31:0]            rdata_d;
  logic [NCH-1:0]         wr, wr_ok, chg, pset;
  logic [NCH-1:0][SW-1:0] shadow, act;

  logic                   auto_q, trg_en_q, pending_q, pending_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ack_q, err_q, upd_q;
  logic [31:0]            rdata_q;

  logic unused_addr;
  assign unused_addr = ^bus.addr[31:DEC_W];

  assign dec       = decode(bus.addr[DEC_W-1:0], NCH);
  assign acc       = bus.wen | bus.ren;
  assign ctrl_wr   = bus.wen & dec.ctrl;
  assign wr_ok_any = |wr_ok;
  assign mapped    = dec.sh | dec.ctrl | dec.stat | dec.cnt;

  assign apply = (ctrl_wr & bus.wdata[CTRL_APPLY]) |
                 (trg_en_q & trg_i) |
                 (auto_q & wr_ok_any);

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_fld
      assign wr[g] = bus.wen & dec.sh & (dec.idx == 4'(g));
      mux_cfg_field #(.SW(SW), .NSEL(NSEL)) u_fld (
        .clk_i    (bus.clk),
        .rst_ni   (bus.rstn),
        .wr_i     (wr[g]),
        .wdata_i  (bus.wdata),
        .auto_i   (auto_q),
        .apply_i  (apply),
        .wr_ok_o  (wr_ok[g]),
        .shadow_o (shadow[g]),
        .act_o    (act[g]),
        .chg_o    (chg[g]),
        .pend_o   (pset[g])
      );
    end
  endgenerate

  // An apply clears pending, but a concurrent write that the apply did not
  // carry over re-arms it in the same edge.
  assign pending_d = apply ? (|pset) : (pending_q | (|pset));
  assign cnt_d     = apply ? cnt_q + 16'd1 : cnt_q;

  assign err_d = acc & (~mapped |
                        (bus.wen & (dec.stat | dec.cnt)) |
                        (bus.wen & dec.sh & ~wr_ok_any));

  always_comb begin
    rdata_d = '0;
    if (bus.ren) begin
      if (dec.sh) begin
        for (int i = 0; i < NCH; i++)
          if (dec.idx == 4'(i)) rdata_d = 32'(shadow[i]);
      end else if (dec.ctrl) begin
        rdata_d[CTRL_AUTO]   = auto_q;
        rdata_d[CTRL_TRG_EN] = trg_en_q;
      end else if (dec.stat) begin
        rdata_d[0] = pending_q;
      end else if (dec.cnt) begin
        rdata_d = 32'(cnt_q);
      end
    end
  end

  always_ff @(posedge bus.clk or negedge bus.rstn) begin
    if (!bus.rstn) begin
      auto_q    <= 1'b0;
      trg_en_q  <= 1'b0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      upd_q     <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        auto_q   <= bus.wdata[CTRL_AUTO];
        trg_en_q <= bus.wdata[CTRL_TRG_EN];
      end
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      ack_q     <= acc;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      upd_q     <= |chg;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign mux_o     = act;
  assign mux_upd_o = upd_q;

endmodule
